glip_stream_checker: RTL and testbench

- Sink for the GLIP Host->Logic FIFO stream (fifo_in_* side of glip_cypressfx3_toplevel).
- Replaces the loopback path when the host transmits a known pattern; the block consumes the stream and checks every word against the expected sequence.
- Reports error and word counts for display on the LCD and for throughput measurement, so host-to-logic integrity is checked independently of the logic-to-host path.

---
 rtl/glip_stream_checker_pkg.sv | 31 +++
 rtl/glip_stream_checker_pattern.sv | 39 +++
 rtl/glip_stream_checker.sv | 180 ++++++++++++++++++
 tb/tb_glip_stream_checker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glip_stream_checker_pkg.sv
// glip_stream_checker_pkg
//   Shared types and helpers for the GLIP Host->Logic stream checker.
//   - state_e      : checker FSM states (IDLE, SYNC, CHECK)
//   - LFSR_TAPS_*  : Fibonacci LFSR tap masks (bit i set = tap on x^(i+1))
//   - lfsr_step()  : one shift of the Fibonacci LFSR for a 16- or 32-bit word
package glip_stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CHECK
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Shift left, feedback (XOR of tapped bits) enters at bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] data,
                                            input int unsigned width);
    logic [31:0] taps;
    logic [31:0] mask;
    logic        fb;
    taps = (width == 32) ? LFSR_TAPS_32 : LFSR_TAPS_16;
    mask = (width == 32) ? '1 : 32'h0000_FFFF;
    fb   = ^(data & taps);
    return ((data << 1) | {31'b0, fb}) & mask;
  endfunction

endpackage

// File: rtl/glip_stream_checker_pattern.sv
// glip_stream_checker_pattern
//   Combinational successor function of the checked pattern.
//   Ports:
//     data          in  WIDTH  word whose successor is required
//     mode          in  1      (only with GLIP_STREAM_CHECKER_LFSR_EN) 1 = LFSR
//     next_expected out WIDTH  value that must follow 'data'
//   Counter pattern: data + 1 (mod 2^WIDTH).
//   LFSR pattern (GLIP_STREAM_CHECKER_LFSR_EN defined): lfsr_step(data);
//   an all-zero word (LFSR lock-up state) restarts from seed 1.
module glip_stream_checker_pattern
  import glip_stream_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
`ifdef GLIP_STREAM_CHECKER_LFSR_EN
  input  logic             mode,
`endif
  output logic [WIDTH-1:0] next_expected
);

`ifdef GLIP_STREAM_CHECKER_LFSR_EN
  logic [31:0] step;

  always_comb begin
    step          = lfsr_step(32'(data), WIDTH);
    next_expected = data + WIDTH'(1);
    if (mode) begin
      if (data == '0) next_expected = WIDTH'(1);
      else            next_expected = step[WIDTH-1:0];
    end
  end
`else
  always_comb begin
    next_expected = data + WIDTH'(1);
  end
`endif

endmodule

// File: rtl/glip_stream_checker.sv
// glip_stream_checker
//   Sink for the GLIP Host->Logic FIFO stream. Consumes words and checks each
//   one against the expected pattern sequence, counting words and mismatches.
//   Optional LFSR pattern: define GLIP_STREAM_CHECKER_LFSR_EN (adds 'mode').
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     enable            level, 1 = accept and check data
//     clear             pulse, zero counters/first-error capture, resync
//     mode              (LFSR build only) 1 = LFSR pattern, 0 = counter
//     in_data/in_valid  Host->Logic word and valid
//     in_ready          registered ready (optionally throttled 1-in-THROTTLE)
//     word_count        accepted words, saturating
//     err_count         mismatched words, saturating
//     err_pulse         one-cycle pulse per mismatch
//     synced            first word has established the expected value
//     first_err_data/_exp  received/expected value of the first mismatch
module glip_stream_checker
  import glip_stream_checker_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned THROTTLE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
`ifdef GLIP_STREAM_CHECKER_LFSR_EN
  input  logic                 mode,
`endif
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_pulse,
  output logic                 synced,
  output logic [WIDTH-1:0]     first_err_data,
  output logic [WIDTH-1:0]     first_err_exp
);

  state_e               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 synced_q, synced_d;
  logic [WIDTH-1:0]     first_err_data_q, first_err_data_d;
  logic [WIDTH-1:0]     first_err_exp_q, first_err_exp_d;

  logic                 thr_ok_d;   // ready allowed in the next cycle
  logic                 hs;
  logic                 mismatch;
  logic [WIDTH-1:0]     next_exp;

  // ---------------------------------------------------------------- throttle
  if (THROTTLE == 1) begin : g_thr_illegal
    $error("glip_stream_checker: THROTTLE=1 is illegal");
    assign thr_ok_d = 1'b1;
  end else if (THROTTLE > 1) begin : g_thr
    localparam int unsigned TW = $clog2(THROTTLE);
    logic [TW-1:0] thr_q, thr_d;

    always_comb begin
      thr_d    = (thr_q == TW'(THROTTLE - 1)) ? '0 : thr_q + TW'(1);
      thr_ok_d = (thr_d != TW'(THROTTLE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) thr_q <= '0;
      else        thr_q <= thr_d;
    end
  end else begin : g_thr_off
    assign thr_ok_d = 1'b1;
  end

  // ------------------------------------------------------------- pattern gen
  // Only the received word is fed to the pattern function: on a match it
  // equals expected_q, so its successor is also the in-sequence successor,
  // and on a mismatch it is exactly the resync value.
  glip_stream_checker_pattern #(
    .WIDTH (WIDTH)
  ) u_pattern (
    .data          (in_data),
`ifdef GLIP_STREAM_CHECKER_LFSR_EN
    .mode          (mode),
`endif
    .next_expected (next_exp)
  );

  assign hs = in_valid && in_ready_q;

`ifdef GLIP_STREAM_CHECKER_LFSR_EN
  assign mismatch = (in_data != expected_q) || (mode && (in_data == '0));
`else
  assign mismatch = (in_data != expected_q);
`endif

  // ------------------------------------------------------- next-state logic
  always_comb begin
    state_d          = state_q;
    expected_d       = expected_q;
    word_count_d     = word_count_q;
    err_count_d      = err_count_q;
    err_pulse_d      = 1'b0;
    synced_d         = synced_q;
    first_err_data_d = first_err_data_q;
    first_err_exp_d  = first_err_exp_q;

    if (clear) begin
      word_count_d     = '0;
      err_count_d      = '0;
      synced_d         = 1'b0;
      first_err_data_d = '0;
      first_err_exp_d  = '0;
      state_d          = enable ? SYNC : IDLE;
    end else begin
      // A word handshaked in the cycle enable drops is still checked.
      if (hs) begin
        if (word_count_q != '1) word_count_d = word_count_q + CNT_WIDTH'(1);
        expected_d = next_exp;
        if (state_q == SYNC) begin
          synced_d = 1'b1;
          state_d  = CHECK;
        end else if (mismatch) begin
          if (err_count_q != '1) err_count_d = err_count_q + CNT_WIDTH'(1);
          err_pulse_d = 1'b1;
          if (err_count_q == '0) begin
            first_err_data_d = in_data;
            first_err_exp_d  = expected_q;
          end
        end
      end

      if (!enable) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        state_d  = SYNC;
        synced_d = 1'b0;
      end
    end

    in_ready_d = (state_d != IDLE) && thr_ok_d;
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      in_ready_q       <= 1'b0;
      expected_q       <= '0;
      word_count_q     <= '0;
      err_count_q      <= '0;
      err_pulse_q      <= 1'b0;
      synced_q         <= 1'b0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
    end else begin
      state_q          <= state_d;
      in_ready_q       <= in_ready_d;
      expected_q       <= expected_d;
      word_count_q     <= word_count_d;
      err_count_q      <= err_count_d;
      err_pulse_q      <= err_pulse_d;
      synced_q         <= synced_d;
      first_err_data_q <= first_err_data_d;
      first_err_exp_q  <= first_err_exp_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign word_count     = word_count_q;
  assign err_count      = err_count_q;
  assign err_pulse      = err_pulse_q;
  assign synced         = synced_q;
  assign first_err_data = first_err_data_q;
  assign first_err_exp  = first_err_exp_q;

endmodule

// File: tb/tb_glip_stream_checker.sv
// tb_glip_stream_checker
//   Randomized bench with a behavioural reference model for
//   glip_stream_checker (WIDTH=16, CNT_WIDTH=12, THROTTLE=4).
//   Define GLIP_STREAM_CHECKER_LFSR_EN to also exercise the LFSR pattern.
module tb_glip_stream_checker;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned CNT_WIDTH = 12;
  localparam int unsigned THROTTLE  = 4;
  localparam int unsigned CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 enable   = 1'b0;
  logic                 clear    = 1'b0;
  logic                 mode     = 1'b0;
  logic [WIDTH-1:0]     in_data  = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CNT_WIDTH-1:0] word_count;
  logic [CNT_WIDTH-1:0] err_count;
  logic                 err_pulse;
  logic                 synced;
  logic [WIDTH-1:0]     first_err_data;
  logic [WIDTH-1:0]     first_err_exp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses   = 0;

  always #5 clk = ~clk;

  glip_stream_checker #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .THROTTLE  (THROTTLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clear          (clear),
`ifdef GLIP_STREAM_CHECKER_LFSR_EN
    .mode           (mode),
`endif
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .word_count     (word_count),
    .err_count      (err_count),
    .err_pulse      (err_pulse),
    .synced         (synced),
    .first_err_data (first_err_data),
    .first_err_exp  (first_err_exp)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  function automatic logic [15:0] tb_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] tb_next(input logic [15:0] v, input logic m);
    if (m && v == 16'd0) return 16'd1;
    if (m)               return tb_lfsr(v);
    return v + 16'd1;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  bit          m_listen = 0;   // sink is offering ready (enabled phase)
  bit          m_ref    = 0;   // a reference word has been seen this phase
  bit          m_pulse  = 0;
  bit          m_synced = 0;
  logic [15:0] m_exp    = '0;
  logic [15:0] m_fe_d   = '0;
  logic [15:0] m_fe_e   = '0;
  int unsigned m_words  = 0;
  int unsigned m_errs   = 0;
  int unsigned m_edges  = 0;   // clock edges since reset release

  function automatic bit m_ready();
    return m_listen && ((m_edges % THROTTLE) != THROTTLE - 1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_listen = 0; m_ref = 0; m_pulse = 0; m_synced = 0; m_exp = '0;
      m_fe_d = '0; m_fe_e = '0; m_words = 0; m_errs = 0; m_edges = 0;
    end else begin
      bit hs;
      hs = in_valid && m_ready();
      m_edges++;
      m_pulse = 0;
      if (clear) begin
        m_words = 0; m_errs = 0; m_synced = 0; m_fe_d = '0; m_fe_e = '0;
        m_listen = enable; m_ref = 0;
      end else begin
        if (hs) begin
          m_words = sat_inc(m_words);
          if (!m_ref) begin
            m_ref = 1; m_synced = 1; m_exp = tb_next(in_data, mode);
          end else if (in_data != m_exp || (mode && in_data == 16'd0)) begin
            if (m_errs == 0) begin m_fe_d = in_data; m_fe_e = m_exp; end
            m_errs  = sat_inc(m_errs);
            m_pulse = 1;
            m_exp   = tb_next(in_data, mode);
          end else begin
            m_exp = tb_next(m_exp, mode);
          end
        end
        if (!enable) m_listen = 0;
        else if (!m_listen) begin m_listen = 1; m_ref = 0; m_synced = 0; end
      end
    end
  end

  // Outputs are registered; compare on the falling edge every cycle.
  always @(negedge clk) begin
    check("in_ready",       32'(in_ready),       32'(m_ready()));
    check("word_count",     32'(word_count),     m_words);
    check("err_count",      32'(err_count),      m_errs);
    check("err_pulse",      32'(err_pulse),      32'(m_pulse));
    check("synced",         32'(synced),         32'(m_synced));
    check("first_err_data", 32'(first_err_data), 32'(m_fe_d));
    check("first_err_exp",  32'(first_err_exp),  32'(m_fe_e));
    if (err_pulse) pulses++;
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    int unsigned g = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && g < 40) begin tick(); g++; end
    if (!in_ready) check("handshake_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur;
    logic [15:0] v;
    logic        r;
    int unsigned lows;
    int unsigned g;

    repeat (3) tick();
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_err_count",  32'(err_count),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_synced",     32'(synced),     32'd0);
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick();

    // 1024-word incrementing stream
    for (int unsigned i = 0; i < 1024; i++) send(16'(i));
    tick();
    check("t1_word_count", 32'(word_count), 32'd1024);
    check("t1_err_count",  32'(err_count),  32'd0);
    check("t1_synced",     32'(synced),     32'd1);

    // single skipped value
    clear = 1'b1; tick(); clear = 1'b0;
    pulses = 0;
    send(16'd5); send(16'd6); send(16'd7); send(16'd9); send(16'd10); send(16'd11);
    tick();
    check("t2_err_count",      32'(err_count),      32'd1);
    check("t2_first_err_data", 32'(first_err_data), 32'd9);
    check("t2_first_err_exp",  32'(first_err_exp),  32'd8);
    check("t2_word_count",     32'(word_count),     32'd6);
    check("t2_pulses",         pulses,              32'd1);

    // wrap-around
    clear = 1'b1; tick(); clear = 1'b0;
    send(16'hFFFE); send(16'hFFFF); send(16'h0000); send(16'h0001);
    tick();
    check("t3_err_count",  32'(err_count),  32'd0);
    check("t3_word_count", 32'(word_count), 32'd4);

    // throttle: valid held for 40 cycles
    cur = 16'd2; lows = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      in_data = cur; in_valid = 1'b1;
      r = in_ready;
      tick();
      if (r) cur = cur + 16'd1;
      else   lows++;
    end
    in_valid = 1'b0;
    check("t4_ready_lows", lows,             32'd10);
    check("t4_word_count", 32'(word_count), 32'd34);
    check("t4_err_count",  32'(err_count),  32'd0);

    // clear coinciding with a handshake
    g = 0;
    while (!in_ready && g < 10) begin tick(); g++; end
    in_data = 16'd55; in_valid = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    send(16'd100); send(16'd101);
    tick();
    check("t5_word_count", 32'(word_count), 32'd2);
    check("t5_err_count",  32'(err_count),  32'd0);
    check("t5_synced",     32'(synced),     32'd1);

    // asynchronous reset mid-stream
    in_data = 16'd102; in_valid = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_word_count", 32'(word_count), 32'd0);
    check("t5_arst_in_ready",   32'(in_ready),   32'd0);
    check("t5_arst_synced",     32'(synced),     32'd0);
    check("t5_arst_first_err",  32'(first_err_data), 32'd0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef GLIP_STREAM_CHECKER_LFSR_EN
    // LFSR pattern
    mode = 1'b1;
    v = 16'h0001;
    for (int unsigned i = 0; i < 256; i++) begin send(v); v = tb_lfsr(v); end
    tick();
    check("t6_err_count",  32'(err_count),  32'd0);
    check("t6_word_count", 32'(word_count), 32'd256);
    check("t6_lfsr_after_1", 32'(tb_lfsr(16'h0001)), 32'h0002);
    check("t6_lfsr_msb",     32'(tb_lfsr(16'h8000)), 32'h0001);
    v = v ^ 16'h0100;
    for (int unsigned i = 0; i < 20; i++) begin send(v); v = tb_lfsr(v); end
    tick();
    check("t6_err_one", 32'(err_count), 32'd1);
    send(16'h0000); send(16'h0001); send(16'h0002);
    tick();
    check("t6_zero_err", 32'(err_count), 32'd2);
    mode = 1'b0;
`else
    v = 16'd0;
`endif

    // randomized traffic
    clear = 1'b1; tick(); clear = 1'b0;
    cur = 16'($urandom);
    for (int unsigned i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 95);
      clear  = ($urandom_range(0, 99) < 2);
`ifdef GLIP_STREAM_CHECKER_LFSR_EN
      if ($urandom_range(0, 99) < 3) mode = ~mode;
`endif
      in_valid = ($urandom_range(0, 99) < 70);
      in_data  = ($urandom_range(0, 9) < 8) ? cur : 16'($urandom);
      r = in_ready;
      tick();
      if (in_valid && r) cur = tb_next(in_data, mode);
    end
    enable = 1'b1; clear = 1'b0; in_valid = 1'b0; mode = 1'b0;

    // counter saturation: almost every word is an error
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 6000; i++) begin
      in_data = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("sat_err_count",  32'(err_count),  32'(CNT_MAX));
    check("sat_word_count", 32'(word_count), 32'(CNT_MAX));

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
